// File: rtl/voice_sequencer_if.sv
// Configuration write port and shared phase/amplitude datapath handshake for voice_sequencer.
// "master" is the sequencer side: it drives the datapath and receives configuration.
interface voice_sequencer_if #(
    parameter int VW = 2
);
    logic               cfg_we;
    logic [VW-1:0]      cfg_voice;
    logic [1:0]         cfg_sel;
    logic [15:0]        cfg_data;

    logic [13:0]        dp_phase;
    logic signed [15:0] dp_amp;
    logic               dp_valid;
    logic signed [15:0] dp_result;

    modport master (
        input  cfg_we, cfg_voice, cfg_sel, cfg_data, dp_result,
        output dp_phase, dp_amp, dp_valid
    );

    modport slave (
        output cfg_we, cfg_voice, cfg_sel, cfg_data, dp_result,
        input  dp_phase, dp_amp, dp_valid
    );
endinterface

// File: rtl/voice_sequencer.sv
// Time-multiplexes one sine/amplitude datapath across NVOICES oscillator voices and
// mixes the returned samples into one saturated 16-bit output per sample tick.
//
// state   | meaning
// S_IDLE  | waiting for sample_tick
// S_ISSUE | one voice per cycle sent to the datapath
// S_DRAIN | LAT cycles waiting for the last results
// S_DONE  | mix_out updated, mix_valid high for one cycle
module voice_sequencer #(
    parameter int NVOICES = 4,
    parameter int LAT     = 0
) (
    input  logic               clk,
    input  logic               reset,
    voice_sequencer_if.master  bus,
    input  logic               resync,
    input  logic               sample_tick,
    output logic signed [15:0] mix_out,
    output logic               mix_valid,
    output logic               busy,
    output logic               overrun
);
    localparam int VW = ($clog2(NVOICES) < 1) ? 1 : $clog2(NVOICES);
    localparam int SW = 16 + VW + 1;
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [VW-1:0] LAST = VW'(NVOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                   state;
    logic [VW-1:0]            idx;
    logic [VW-1:0]            idx_inc;
    logic [VW-1:0]            issue_sel;
    logic [DW-1:0]            drain_cnt;
    logic signed [SW-1:0]     sum;
    logic signed [SW-1:0]     sum_nxt;
    logic                     res_vld;
    logic                     cfg_hit;
    logic [13:0]              issue_phase;
    logic [15:0]              issue_amp;

    logic [NVOICES-1:0][15:0] amp, amp_nxt;
    logic [NVOICES-1:0][15:0] padd, padd_nxt;
    logic [NVOICES-1:0][15:0] poff, poff_nxt;
    logic [NVOICES-1:0][15:0] acc, acc_nxt;
    logic [NVOICES-1:0]       en, en_nxt;

    function automatic logic [15:0] sat16(input logic signed [SW-1:0] s);
        if ((&s[SW-1:15]) || !(|s[SW-1:15]))
            return s[15:0];
        else if (s[SW-1])
            return 16'h8000;
        else
            return 16'h7fff;
    endfunction

    assign cfg_hit = bus.cfg_we && (int'(bus.cfg_voice) < NVOICES);

    // Precedence: issue advance, then resync (old offsets), then config write.
    always_comb begin
        acc_nxt  = acc;
        amp_nxt  = amp;
        padd_nxt = padd;
        poff_nxt = poff;
        en_nxt   = en;
        if (state == S_ISSUE && en[idx])
            acc_nxt[idx] = acc[idx] + padd[idx];
        if (resync)
            acc_nxt = poff;
        if (cfg_hit) begin
            case (bus.cfg_sel)
                2'd0: amp_nxt[bus.cfg_voice]  = bus.cfg_data;
                2'd1: padd_nxt[bus.cfg_voice] = bus.cfg_data;
                2'd2: poff_nxt[bus.cfg_voice] = bus.cfg_data;
                2'd3: en_nxt[bus.cfg_voice]   = bus.cfg_data[0];
            endcase
        end
    end

    // Datapath outputs are registered from next-state values so that an issue
    // reflects every write and resync that landed on the same edge.
    assign idx_inc     = idx + 1'b1;
    assign issue_sel   = (state == S_IDLE) ? '0 : idx_inc;
    assign issue_phase = acc_nxt[issue_sel][15:2];
    assign issue_amp   = en_nxt[issue_sel] ? amp_nxt[issue_sel] : 16'h0000;

    generate
        if (LAT == 0) begin : g_comb_dp
            assign res_vld = bus.dp_valid;
        end else begin : g_pipe_dp
            logic [LAT-1:0] vld_sr;
            always_ff @(posedge clk) begin
                if (reset)
                    vld_sr <= '0;
                else
                    vld_sr <= LAT'({vld_sr, bus.dp_valid});
            end
            assign res_vld = vld_sr[LAT-1];
        end
    endgenerate

    assign sum_nxt = sum + (res_vld ? $signed({{(SW-16){bus.dp_result[15]}}, bus.dp_result})
                                    : $signed({SW{1'b0}}));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            drain_cnt    <= '0;
            sum          <= '0;
            amp          <= '0;
            padd         <= '0;
            poff         <= '0;
            acc          <= '0;
            en           <= '0;
            bus.dp_phase <= '0;
            bus.dp_amp   <= '0;
            bus.dp_valid <= 1'b0;
            mix_out      <= '0;
            mix_valid    <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            amp  <= amp_nxt;
            padd <= padd_nxt;
            poff <= poff_nxt;
            acc  <= acc_nxt;
            en   <= en_nxt;

            if (sample_tick && state != S_IDLE)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    mix_valid <= 1'b0;
                    if (sample_tick) begin
                        state        <= S_ISSUE;
                        idx          <= '0;
                        sum          <= '0;
                        busy         <= 1'b1;
                        bus.dp_valid <= 1'b1;
                        bus.dp_phase <= issue_phase;
                        bus.dp_amp   <= issue_amp;
                    end
                end
                S_ISSUE: begin
                    sum <= sum_nxt;
                    if (idx == LAST) begin
                        bus.dp_valid <= 1'b0;
                        if (LAT > 0) begin
                            state     <= S_DRAIN;
                            drain_cnt <= DW'(LAT - 1);
                        end else begin
                            state     <= S_DONE;
                            mix_out   <= sat16(sum_nxt);
                            mix_valid <= 1'b1;
                        end
                    end else begin
                        idx          <= idx_inc;
                        bus.dp_valid <= 1'b1;
                        bus.dp_phase <= issue_phase;
                        bus.dp_amp   <= issue_amp;
                    end
                end
                S_DRAIN: begin
                    sum <= sum_nxt;
                    if (drain_cnt == '0) begin
                        state     <= S_DONE;
                        mix_out   <= sat16(sum_nxt);
                        mix_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    mix_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_sequencer.sv
// Bench for voice_sequencer: a combinational (LAT=0) and a 2-stage (LAT=2) instance share
// stimulus; both are compared every cycle against a frame-level reference model.
module tb_voice_sequencer;
    localparam int N  = 4;
    localparam int VW = 2;

    logic              clk = 1'b0;
    logic              reset, tick, resync, cfg_we;
    logic [VW-1:0]     cfg_voice;
    logic [1:0]        cfg_sel;
    logic [15:0]       cfg_data;
    logic signed [15:0] mix0, mix2, stage1, stage2;
    logic              mv0, mv2, busy0, busy2, ovr0, ovr2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    voice_sequencer_if #(.VW(VW)) bus0 ();
    voice_sequencer_if #(.VW(VW)) bus2 ();

    assign bus0.cfg_we = cfg_we;  assign bus0.cfg_voice = cfg_voice;
    assign bus0.cfg_sel = cfg_sel; assign bus0.cfg_data = cfg_data;
    assign bus2.cfg_we = cfg_we;  assign bus2.cfg_voice = cfg_voice;
    assign bus2.cfg_sel = cfg_sel; assign bus2.cfg_data = cfg_data;

    // Stub datapaths return the amplitude itself, immediately or two cycles later.
    assign bus0.dp_result = bus0.dp_amp;
    always @(posedge clk) begin
        stage1 <= bus2.dp_amp;
        stage2 <= stage1;
    end
    assign bus2.dp_result = stage2;

    voice_sequencer #(.NVOICES(N), .LAT(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .resync(resync), .sample_tick(tick),
        .mix_out(mix0), .mix_valid(mv0), .busy(busy0), .overrun(ovr0));

    voice_sequencer #(.NVOICES(N), .LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .resync(resync), .sample_tick(tick),
        .mix_out(mix2), .mix_valid(mv2), .busy(busy2), .overrun(ovr2));

    // Reference model: per-voice registers plus, per instance, the cycle number
    // within the current frame (fc, -1 when idle; tick is cycle 0).
    logic [15:0]        m_acc [N];
    logic [15:0]        m_add [N];
    logic [15:0]        m_off [N];
    logic signed [15:0] m_amp [N];
    bit                 m_en  [N];
    int lats [2] = '{0, 2};
    int fc [2];
    int m_mix [2];
    bit m_ovr [2];
    int last_ph [2];
    int last_amp [2];
    int fsum;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    task automatic model_edge();
        int v;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_acc[i] = 0; m_add[i] = 0; m_off[i] = 0; m_amp[i] = 0; m_en[i] = 0;
            end
            for (int d = 0; d < 2; d++) begin
                fc[d] = -1; m_mix[d] = 0; m_ovr[d] = 0; last_ph[d] = 0; last_amp[d] = 0;
            end
            return;
        end
        v = (fc[0] >= 1 && fc[0] <= N) ? fc[0] - 1 : -1;
        if (v >= 0 && m_en[v]) begin
            fsum += int'(m_amp[v]);
            m_acc[v] = 16'(m_acc[v] + m_add[v]);
        end
        if (resync) m_acc = m_off;
        if (cfg_we && int'(cfg_voice) < N) begin
            case (cfg_sel)
                2'd0: m_amp[cfg_voice] = cfg_data;
                2'd1: m_add[cfg_voice] = cfg_data;
                2'd2: m_off[cfg_voice] = cfg_data;
                2'd3: m_en[cfg_voice]  = cfg_data[0];
            endcase
        end
        if (tick && fc[0] == -1 && fc[1] == -1) fsum = 0;
        for (int d = 0; d < 2; d++) begin
            if (fc[d] == -1) begin
                if (tick) fc[d] = 1;
            end else begin
                if (tick) m_ovr[d] = 1;
                fc[d] = (fc[d] == N + lats[d] + 1) ? -1 : fc[d] + 1;
            end
            if (fc[d] == N + lats[d] + 1) m_mix[d] = sat(fsum);
        end
    endtask

    task automatic chk_dut(input int d, input string p, input logic [13:0] ph,
                           input logic signed [15:0] amp, input logic vld, input logic mv,
                           input logic signed [15:0] mix, input logic bsy, input logic ovr);
        int f, l;
        f = fc[d];
        l = lats[d];
        if (f >= 1 && f <= N) begin
            last_ph[d]  = int'(m_acc[f-1][15:2]);
            last_amp[d] = m_en[f-1] ? int'(m_amp[f-1]) : 0;
        end
        chk({p, "busy"},      int'(bsy), int'(f >= 1 && f <= N + l + 1));
        chk({p, "dp_valid"},  int'(vld), int'(f >= 1 && f <= N));
        chk({p, "dp_phase"},  int'(ph),  last_ph[d]);
        chk({p, "dp_amp"},    int'(amp), last_amp[d]);
        chk({p, "mix_valid"}, int'(mv),  int'(f == N + l + 1));
        chk({p, "mix_out"},   int'(mix), m_mix[d]);
        chk({p, "overrun"},   int'(ovr), int'(m_ovr[d]));
    endtask

    task automatic cyc();
        model_edge();
        @(negedge clk);
        tick = 0; cfg_we = 0; resync = 0; reset = 0;
        chk_dut(0, "L0.", bus0.dp_phase, bus0.dp_amp, bus0.dp_valid, mv0, mix0, busy0, ovr0);
        chk_dut(1, "L2.", bus2.dp_phase, bus2.dp_amp, bus2.dp_valid, mv2, mix2, busy2, ovr2);
    endtask

    task automatic wr(input int v, input int sel, input int data);
        cfg_we = 1; cfg_voice = VW'(v); cfg_sel = 2'(sel); cfg_data = 16'(data);
        cyc();
    endtask

    task automatic set_rand_cfg();
        cfg_we    = 1;
        cfg_voice = VW'($urandom);
        cfg_sel   = 2'($urandom);
        cfg_data  = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                                : 16'($urandom_range(0, 16000) - 8000);
    endtask

    // One full frame from idle; returns the cycle of each mix_valid and voice0's phase.
    task automatic frame(output int c0, output int c2, output int ph0);
        c0 = -1; c2 = -1; ph0 = -1;
        tick = 1;
        cyc();
        for (int k = 1; k <= 8; k++) begin
            if (k == 1) ph0 = int'(bus0.dp_phase);
            if (mv0 && c0 < 0) c0 = k;
            if (mv2 && c2 < 0) c2 = k;
            if (k < 8) cyc();
        end
    endtask

    initial begin
        int c0, c2, ph, nmv0, nmv2;
        int exp4 [3] = '{'h2000, 'h1000, 'h0000};
        reset = 1; tick = 0; resync = 0; cfg_we = 0;
        cfg_voice = '0; cfg_sel = '0; cfg_data = '0; fsum = 0;
        for (int d = 0; d < 2; d++) fc[d] = -1;
        cyc();
        cyc();
        chk("rst_mix0", int'(mix0), 0);
        chk("rst_busy2", int'(busy2), 0);
        chk("rst_ovr0", int'(ovr0), 0);

        // all voices disabled
        frame(c0, c2, ph);
        chk("t1_mv_cycle_lat0", c0, 5);
        chk("t1_mv_cycle_lat2", c2, 7);
        chk("t1_mix0", int'(mix0), 0);

        wr(0, 0, 1000); wr(1, 0, -300); wr(0, 3, 1); wr(1, 3, 1);
        frame(c0, c2, ph);
        chk("t2_mix0", int'(mix0), 700);
        chk("t2_mix2", int'(mix2), 700);
        wr(0, 1, 'h0400); wr(0, 2, 0);
        resync = 1; cyc();
        for (int i = 0; i < 3; i++) begin
            frame(c0, c2, ph);
            chk($sformatf("t2_phase%0d", i), ph, 'h100 * i);
        end

        for (int v = 0; v < N; v++) begin wr(v, 0, 20000); wr(v, 3, 1); end
        frame(c0, c2, ph);
        chk("t3_satpos0", int'(mix0), 32767);
        chk("t3_satpos2", int'(mix2), 32767);
        for (int v = 0; v < N; v++) wr(v, 0, -20000);
        frame(c0, c2, ph);
        chk("t3_satneg0", int'(mix0), -32768);
        chk("t3_satneg2", int'(mix2), -32768);

        wr(0, 1, 'hC000); wr(0, 2, 'h8000);
        resync = 1; cyc();
        for (int i = 0; i < 3; i++) begin
            frame(c0, c2, ph);
            chk($sformatf("t4_wrap%0d", i), ph, exp4[i]);
        end
        resync = 1; cyc();
        tick = 1; cyc();
        resync = 1; cyc();
        for (int k = 2; k < 8; k++) cyc();
        frame(c0, c2, ph);
        chk("t4_resync_vs_issue", ph, 'h2000);
        cfg_we = 1; cfg_voice = '0; cfg_sel = 2'd2; cfg_data = 16'h4000; resync = 1;
        cyc();
        frame(c0, c2, ph);
        chk("t4_resync_vs_write", ph, 'h2000);
        resync = 1; cyc();
        frame(c0, c2, ph);
        chk("t4_new_offset", ph, 'h1000);

        tick = 1; cyc();
        cyc();
        chk("t5_ovr_before", int'(ovr0), 0);
        tick = 1; cyc();
        chk("t5_ovr_lat0", int'(ovr0), 1);
        chk("t5_ovr_lat2", int'(ovr2), 1);
        nmv0 = 0; nmv2 = 0;
        for (int k = 4; k <= 9; k++) begin
            cyc();
            if (mv0) nmv0++;
            if (mv2) nmv2++;
        end
        chk("t5_one_mv_lat0", nmv0, 1);
        chk("t5_one_mv_lat2", nmv2, 1);

        reset = 1; cyc();
        tick = 1; cyc();
        cyc();
        reset = 1; cyc();
        chk("t6_busy", int'(busy0), 0);
        chk("t6_dp_valid", int'(bus0.dp_valid), 0);
        chk("t6_ovr", int'(ovr0), 0);
        chk("t6_mix", int'(mix2), 0);
        nmv0 = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (mv0 || mv2) nmv0++;
        end
        chk("t6_no_mv", nmv0, 0);
        frame(c0, c2, ph);
        chk("t6_next_lat0", c0, 5);
        chk("t6_next_lat2", c2, 7);

        // randomized frames with writes, resyncs, stray ticks and occasional resets
        for (int f = 0; f < 60; f++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int i = 0; i < nw; i++) begin set_rand_cfg(); cyc(); end
            if ($urandom_range(0, 3) == 0) begin resync = 1; cyc(); end
            tick = 1; cyc();
            for (int k = 1; k <= 9; k++) begin
                if ($urandom_range(0, 3) == 0) set_rand_cfg();
                if ($urandom_range(0, 5) == 0) resync = 1;
                if (fc[0] >= 1 && fc[0] <= N + 1 && fc[1] >= 1 && $urandom_range(0, 7) == 0)
                    tick = 1;
                if ($urandom_range(0, 49) == 0) reset = 1;
                cyc();
            end
            for (int g = 0; g < 20 && (fc[0] != -1 || fc[1] != -1); g++) cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
